// File: rtl/simd_issue_arbiter.sv
// ----------------------------------------------------------------------------
// simd_issue_arbiter
//
// Shares one SIMD ALU issue port between N_REQ driver instances. A round-robin
// arbiter locks onto one requesting driver. It forwards that driver's
// instruction downstream. An in-order tag FIFO records which driver issued each
// instruction, so each in-order commit from the ALU is steered back to the
// driver that issued it.
//
// Ports
//   i_clk, i_rst      clock; asynchronous active-low reset
//   req_rdys/req_acks per-driver instruction valid / accept (acks one-hot or 0)
//   i_pc, i_warpid,
//   i_bofs, i_aofs    per-driver instruction payload
//   inst_rdy/inst_ack downstream instruction valid / accept
//   o_pc, o_warpid,
//   o_bofs, o_aofs    payload of the locked driver (0 while idle)
//   o_reqid           index of the locked driver (0 while idle)
//   commit_dval       one in-order commit from the ALU pipeline
//   commit_dvals      registered commit pulse steered to the issuing driver
//   o_err             sticky: a commit arrived with nothing pending
//   o_dbg_lock        1 while the FSM is in LOCK
//   o_dbg_count       number of issued-but-uncommitted instructions
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A driver keeps req_rdys[i] and its payload stable from the
// moment it rises until the cycle in which req_acks[i] is high. Downstream
// asserts inst_ack only while inst_rdy is high. req_acks[g] is inst_ack
// routed to the locked driver g, so the upstream and downstream transfers
// always happen in the same cycle.
// ----------------------------------------------------------------------------
module simd_issue_arbiter #(
    parameter int N_REQ     = 2,
    parameter int N_PENDING = 4,
    parameter int INST_BW   = 8,
    parameter int WID_BW    = 4,
    parameter int WBW       = 8,
    parameter int VDIM      = 2,
    localparam int RW = $clog2(N_REQ),
    localparam int CW = $clog2(N_PENDING + 1),
    localparam int PW = (N_PENDING > 1) ? $clog2(N_PENDING) : 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [N_REQ-1:0]                       req_rdys,
    output logic [N_REQ-1:0]                       req_acks,
    input  logic [N_REQ-1:0][INST_BW-1:0]          i_pc,
    input  logic [N_REQ-1:0][WID_BW-1:0]           i_warpid,
    input  logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]    i_bofs,
    input  logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]    i_aofs,
    output logic                                   inst_rdy,
    input  logic                                   inst_ack,
    output logic [INST_BW-1:0]                     o_pc,
    output logic [WID_BW-1:0]                      o_warpid,
    output logic [VDIM-1:0][WBW-1:0]               o_bofs,
    output logic [VDIM-1:0][WBW-1:0]               o_aofs,
    output logic [RW-1:0]                          o_reqid,
    input  logic                                   commit_dval,
    output logic [N_REQ-1:0]                       commit_dvals,
    output logic                                   o_err,
    output logic                                   o_dbg_lock,
    output logic [CW-1:0]                          o_dbg_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [CW-1:0] FULL_CNT  = CW'(N_PENDING);
    localparam logic [RW:0]   NREQ_W    = (RW + 1)'(N_REQ);
    localparam logic [RW-1:0] LAST_REQ  = RW'(N_REQ - 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(N_PENDING - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [RW-1:0]     grant_q, grant_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [N_REQ-1:0]  commit_dvals_q, commit_dvals_d;
    logic              err_q, err_d;
    logic [RW-1:0]     tag_mem_q [N_PENDING];

    // ------------------------------------------------------------------------
    // Issue / commit qualifiers
    // ------------------------------------------------------------------------
    logic              locked;
    logic              issue_rdy;
    logic              fire;
    logic              pop;
    logic              bad_commit;
    logic [N_REQ-1:0]  grant_oh;
    logic [N_REQ-1:0]  cand;

    assign locked     = (state_q == S_LOCK);
    // count never exceeds N_PENDING, so "not full" is a plain inequality.
    assign issue_rdy  = locked && (count_q != FULL_CNT);
    assign fire       = issue_rdy && inst_ack;
    assign pop        = commit_dval && (count_q != '0);
    assign bad_commit = commit_dval && (count_q == '0);

    // One-hot of the driver being accepted this cycle (zero if no transfer).
    assign grant_oh   = fire ? (N_REQ'(1) << grant_q) : '0;

    // The driver just accepted still shows rdy for its old item this cycle,
    // so it is excluded from the next pick. It competes again next cycle.
    assign cand       = req_rdys & ~grant_oh;

    // ------------------------------------------------------------------------
    // Round-robin search: first candidate at or above rr_q, wrapping at N_REQ.
    // The sum is one bit wider so the wrap works for any N_REQ.
    // ------------------------------------------------------------------------
    logic              found;
    logic [RW-1:0]     win;
    logic [RW:0]       sum;
    logic [RW-1:0]     idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_q} + (RW + 1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[RW-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant FSM. Arbitration happens while idle and on the cycle the locked
    // driver is accepted. Otherwise the grant is held, including while the tag
    // FIFO is full.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (!locked || fire) begin
            if (found) begin
                state_d = S_LOCK;
                grant_d = win;
                rr_d    = (win == LAST_REQ) ? '0 : win + RW'(1);
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag FIFO bookkeeping and commit steering
    // ------------------------------------------------------------------------
    always_comb begin
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        commit_dvals_d = '0;
        err_d          = err_q | bad_commit;

        // A push and a pop in the same cycle leave the count unchanged.
        unique case ({fire, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d       = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
            commit_dvals_d = N_REQ'(1) << tag_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            rr_q           <= '0;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            commit_dvals_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            commit_dvals_q <= commit_dvals_d;
            err_q          <= err_d;
        end
    end

    // Tag storage holds data only. Stale entries are never read because the
    // pointers and count are reset.
    always_ff @(posedge i_clk) begin
        if (fire) begin
            tag_mem_q[wr_ptr_q] <= grant_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The payload is forced to zero while idle, so nothing leaks
    // through from an unlocked driver.
    // ------------------------------------------------------------------------
    assign inst_rdy     = issue_rdy;
    assign req_acks     = grant_oh;
    assign o_reqid      = locked ? grant_q : '0;
    assign o_pc         = locked ? i_pc[grant_q] : '0;
    assign o_warpid     = locked ? i_warpid[grant_q] : '0;
    assign o_bofs       = locked ? i_bofs[grant_q] : '0;
    assign o_aofs       = locked ? i_aofs[grant_q] : '0;
    assign commit_dvals = commit_dvals_q;
    assign o_err        = err_q;
    assign o_dbg_lock   = locked;
    assign o_dbg_count  = count_q;

endmodule

// File: tb/tb_simd_issue_arbiter.sv
// ----------------------------------------------------------------------------
// tb_simd_issue_arbiter
//
// The model is a request-level reference. It has a lock flag, a granted index,
// a round-robin pointer and a queue of issued driver ids. A compare process
// checks every DUT output against it on each falling edge. Driver stimulus
// comes from per-driver item queues.
// ----------------------------------------------------------------------------
module tb_simd_issue_arbiter;

  localparam int NREQ    = 2;
  localparam int NP      = 4;
  localparam int INST_BW = 8;
  localparam int WID_BW  = 4;
  localparam int WBW     = 8;
  localparam int VDIM    = 2;
  localparam int RW      = $clog2(NREQ);
  localparam int CW      = $clog2(NP + 1);
  localparam int OW      = VDIM * WBW;

  typedef struct packed {
    logic [INST_BW-1:0]        pc;
    logic [WID_BW-1:0]         wid;
    logic [VDIM-1:0][WBW-1:0]  bofs;
    logic [VDIM-1:0][WBW-1:0]  aofs;
  } item_t;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // DUT
  // --------------------------------------------------------------------------
  logic [NREQ-1:0]                      req_rdys = '0;
  logic [NREQ-1:0]                      req_acks;
  logic [NREQ-1:0][INST_BW-1:0]         i_pc = '0;
  logic [NREQ-1:0][WID_BW-1:0]          i_warpid = '0;
  logic [NREQ-1:0][VDIM-1:0][WBW-1:0]   i_bofs = '0;
  logic [NREQ-1:0][VDIM-1:0][WBW-1:0]   i_aofs = '0;
  logic                                 inst_rdy;
  logic                                 inst_ack = 1'b0;
  logic [INST_BW-1:0]                   o_pc;
  logic [WID_BW-1:0]                    o_warpid;
  logic [VDIM-1:0][WBW-1:0]             o_bofs;
  logic [VDIM-1:0][WBW-1:0]             o_aofs;
  logic [RW-1:0]                        o_reqid;
  logic                                 commit_dval = 1'b0;
  logic [NREQ-1:0]                      commit_dvals;
  logic                                 o_err;
  logic                                 o_dbg_lock;
  logic [CW-1:0]                        o_dbg_count;

  simd_issue_arbiter #(
    .N_REQ(NREQ), .N_PENDING(NP), .INST_BW(INST_BW),
    .WID_BW(WID_BW), .WBW(WBW), .VDIM(VDIM)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .req_rdys(req_rdys), .req_acks(req_acks),
    .i_pc(i_pc), .i_warpid(i_warpid), .i_bofs(i_bofs), .i_aofs(i_aofs),
    .inst_rdy(inst_rdy), .inst_ack(inst_ack),
    .o_pc(o_pc), .o_warpid(o_warpid), .o_bofs(o_bofs), .o_aofs(o_aofs),
    .o_reqid(o_reqid),
    .commit_dval(commit_dval), .commit_dvals(commit_dvals),
    .o_err(o_err), .o_dbg_lock(o_dbg_lock), .o_dbg_count(o_dbg_count)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_mis = 0;

  item_t drv0_q[$];
  item_t drv1_q[$];

  bit               m_lock = 1'b0;
  int               m_g = 0;
  int               m_rr = 0;
  int               m_tags[$];
  bit               m_err = 1'b0;
  logic [NREQ-1:0]  m_pulse = '0;

  int ack_log[$];
  int cd_log[$];

  int ack_mode = 0;     // 0 never, 1 whenever ready, 2 random
  int commit_mode = 0;  // 0 never, 1 whenever pending, 2 25%, 3 forced, 4 50%
  bit fill_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t head(input int d);
    item_t it;
    it = '0;
    if (d == 0 && drv0_q.size() > 0) it = drv0_q[0];
    else if (d == 1 && drv1_q.size() > 0) it = drv1_q[0];
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.pc   = INST_BW'($urandom);
    it.wid  = WID_BW'($urandom);
    it.bofs = OW'($urandom);
    it.aofs = OW'($urandom);
    return it;
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic push_item(input int d);
    if (d == 0) drv0_q.push_back(rand_item());
    else drv1_q.push_back(rand_item());
  endtask

  task automatic apply_drivers();
    item_t h0, h1;
    h0 = head(0);
    h1 = head(1);
    req_rdys    = {drv1_q.size() > 0, drv0_q.size() > 0};
    i_pc[0]     = h0.pc;   i_pc[1]     = h1.pc;
    i_warpid[0] = h0.wid;  i_warpid[1] = h1.wid;
    i_bofs[0]   = h0.bofs; i_bofs[1]   = h1.bofs;
    i_aofs[0]   = h0.aofs; i_aofs[1]   = h1.aofs;
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_g = 0;
    m_rr = 0;
    m_tags.delete();
    m_err = 1'b0;
    m_pulse = '0;
  endtask

  // Reference behaviour for one rising edge, from the inputs held that cycle.
  task automatic model_update();
    bit rdy_e, fire_e, found;
    int cand, d;
    rdy_e  = m_lock && (m_tags.size() < NP);
    fire_e = rdy_e && inst_ack;
    if (commit_dval && m_tags.size() > 0) begin
      m_pulse = NREQ'(1 << m_tags.pop_front());
    end else begin
      m_pulse = '0;
      if (commit_dval) m_err = 1'b1;
    end
    if (fire_e) begin
      m_tags.push_back(m_g);
      if (m_g == 0) void'(drv0_q.pop_front());
      else void'(drv1_q.pop_front());
    end
    if (!m_lock || fire_e) begin
      cand = int'(req_rdys);
      if (fire_e) cand[m_g] = 1'b0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        d = (m_rr + k) % NREQ;
        if (!found && cand[d]) begin
          found = 1'b1;
          m_g = d;
        end
      end
      if (found) begin
        m_lock = 1'b1;
        m_rr = (m_g + 1) % NREQ;
      end else begin
        m_lock = 1'b0;
      end
    end
  endtask

  // One clock cycle: model follows the edge, new inputs go in 1 time unit
  // later, and the task returns just after the falling edge.
  task automatic step();
    bit rdy_e;
    @(posedge clk);
    if (rst_n) model_update();
    #1;
    if (fill_en) begin
      if ($urandom_range(0, 3) == 0 && drv0_q.size() < 3) push_item(0);
      if ($urandom_range(0, 3) == 0 && drv1_q.size() < 3) push_item(1);
    end
    rdy_e = m_lock && (m_tags.size() < NP);
    case (ack_mode)
      1:       inst_ack = rdy_e;
      2:       inst_ack = rdy_e && ($urandom_range(0, 1) == 1);
      default: inst_ack = 1'b0;
    endcase
    case (commit_mode)
      1:       commit_dval = (m_tags.size() > 0);
      2:       commit_dval = (m_tags.size() > 0) && ($urandom_range(0, 3) == 0);
      3:       commit_dval = 1'b1;
      4:       commit_dval = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
      default: commit_dval = 1'b0;
    endcase
    apply_drivers();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    ack_mode = 1;
    commit_mode = 1;
    fill_en = 1'b0;
    for (int k = 0; k < 60 && (drv0_q.size() > 0 || drv1_q.size() > 0 ||
                               m_tags.size() > 0 || m_lock); k++) begin
      step();
    end
    step();
    check("drain_count", 64'(o_dbg_count), 64'(0));
    check("drain_lock", 64'(o_dbg_lock), 64'(0));
  endtask

  // --------------------------------------------------------------------------
  // Compare process
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] prev_rdy = '0;
  logic [NREQ-1:0] prev_ack = '0;

  always @(negedge clk) begin
    bit e_rdy, e_fire;
    logic [NREQ-1:0] e_acks;
    item_t h;
    if (!rst_n) begin
      check("rst_inst_rdy", 64'(inst_rdy), 64'(0));
      check("rst_req_acks", 64'(req_acks), 64'(0));
      check("rst_commit_dvals", 64'(commit_dvals), 64'(0));
      check("rst_err", 64'(o_err), 64'(0));
      check("rst_pc", 64'(o_pc), 64'(0));
      check("rst_reqid", 64'(o_reqid), 64'(0));
      check("rst_count", 64'(o_dbg_count), 64'(0));
      prev_rdy = '0;
      prev_ack = '0;
    end else begin
      e_rdy  = m_lock && (m_tags.size() < NP);
      e_fire = e_rdy && inst_ack;
      e_acks = e_fire ? NREQ'(1 << m_g) : '0;
      h      = m_lock ? head(m_g) : '0;
      check("inst_rdy", 64'(inst_rdy), 64'(e_rdy));
      check("req_acks", 64'(req_acks), 64'(e_acks));
      check("reqid", 64'(o_reqid), m_lock ? 64'(m_g) : 64'(0));
      check("pc", 64'(o_pc), 64'(h.pc));
      check("warpid", 64'(o_warpid), 64'(h.wid));
      check("bofs", 64'(o_bofs), 64'(h.bofs));
      check("aofs", 64'(o_aofs), 64'(h.aofs));
      check("commit_dvals", 64'(commit_dvals), 64'(m_pulse));
      check("err", 64'(o_err), 64'(m_err));
      check("lock", 64'(o_dbg_lock), 64'(m_lock));
      check("count", 64'(o_dbg_count), 64'(m_tags.size()));
      // A driver may only drop rdy after the DUT acked it.
      for (int d = 0; d < NREQ; d++) begin
        if (prev_rdy[d] && !prev_ack[d]) check("rdy_hold", 64'(req_rdys[d]), 64'(1));
      end
      prev_rdy = req_rdys;
      prev_ack = req_acks;
      if (req_acks == 2'b01) ack_log.push_back(0);
      else if (req_acks == 2'b10) ack_log.push_back(1);
      else if (req_acks != '0) ack_log.push_back(9);
      if (commit_dvals != '0) cd_log.push_back(int'(commit_dvals));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int exp_t1[4];
    int exp_t4a[3];
    int exp_t4c[3];
    exp_t1  = '{0, 1, 0, 1};
    exp_t4a = '{0, 1, 1};
    exp_t4c = '{1, 2, 2};

    model_reset();
    apply_drivers();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both drivers streaming, ack every ready cycle: grants alternate.
    for (int k = 0; k < 4; k++) begin push_item(0); push_item(1); end
    ack_mode = 1;
    commit_mode = 1;
    step();
    check("t1_cycle0_rdy", 64'(inst_rdy), 64'(0));
    step();
    check("t1_cycle1_rdy", 64'(inst_rdy), 64'(1));
    check("t1_cycle1_reqid", 64'(o_reqid), 64'(0));
    repeat (10) step();
    check("t1_nacks", 64'(ack_log.size()), 64'(8));
    for (int k = 0; k < 4; k++)
      check("t1_grant", 64'((k < ack_log.size()) ? ack_log[k] : -1), 64'(exp_t1[k]));
    drain();

    // Only driver 1 with three items.
    ack_log.delete();
    for (int k = 0; k < 3; k++) push_item(1);
    repeat (10) step();
    check("t2_nacks", 64'(ack_log.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      check("t2_grant", 64'((k < ack_log.size()) ? ack_log[k] : -1), 64'(1));
    drain();

    // No commits: exactly NP issues, then the grant is held with rdy low.
    ack_log.delete();
    for (int k = 0; k < 4; k++) begin push_item(0); push_item(1); end
    commit_mode = 0;
    repeat (10) step();
    check("t3_nacks", 64'(ack_log.size()), 64'(4));
    check("t3_full_rdy", 64'(inst_rdy), 64'(0));
    check("t3_full_lock", 64'(o_dbg_lock), 64'(1));
    check("t3_full_count", 64'(o_dbg_count), 64'(4));
    commit_mode = 3;
    step();
    check("t3_commit_rdy", 64'(inst_rdy), 64'(0));
    commit_mode = 0;
    step();
    check("t3_after_commit_rdy", 64'(inst_rdy), 64'(1));
    drain();

    // Issue drv0, drv1, drv1, then commit all three.
    ack_log.delete();
    cd_log.delete();
    commit_mode = 0;
    push_item(0);
    for (int k = 0; k < 20 && ack_log.size() < 1; k++) step();
    push_item(1);
    push_item(1);
    for (int k = 0; k < 20 && ack_log.size() < 3; k++) step();
    check("t4_nacks", 64'(ack_log.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      check("t4_grant", 64'((k < ack_log.size()) ? ack_log[k] : -1), 64'(exp_t4a[k]));
    ack_mode = 0;
    commit_mode = 1;
    repeat (6) step();
    check("t4_npulses", 64'(cd_log.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      check("t4_pulse", 64'((k < cd_log.size()) ? cd_log[k] : -1), 64'(exp_t4c[k]));

    // Commit with nothing pending.
    check("t5_err_before", 64'(o_err), 64'(0));
    commit_mode = 3;
    step();
    commit_mode = 0;
    step();
    check("t5_err", 64'(o_err), 64'(1));
    check("t5_cdvals", 64'(commit_dvals), 64'(0));
    check("t5_count", 64'(o_dbg_count), 64'(0));
    repeat (3) step();
    check("t5_err_sticky", 64'(o_err), 64'(1));

    // Asynchronous reset while locked with two pending.
    ack_log.delete();
    for (int k = 0; k < 3; k++) push_item(0);
    ack_mode = 1;
    for (int k = 0; k < 20 && ack_log.size() < 2; k++) step();
    ack_mode = 0;
    step();
    step();
    check("t6_lock", 64'(o_dbg_lock), 64'(1));
    check("t6_count", 64'(o_dbg_count), 64'(2));
    check("t6_rdy", 64'(inst_rdy), 64'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    drv0_q.delete();
    drv1_q.delete();
    apply_drivers();
    #1;
    check("t6_rst_rdy", 64'(inst_rdy), 64'(0));
    check("t6_rst_count", 64'(o_dbg_count), 64'(0));
    check("t6_rst_err", 64'(o_err), 64'(0));
    check("t6_rst_lock", 64'(o_dbg_lock), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_item(0);
    push_item(1);
    ack_mode = 1;
    commit_mode = 1;
    step();
    check("t6_restart_rdy0", 64'(inst_rdy), 64'(0));
    step();
    check("t6_restart_rdy1", 64'(inst_rdy), 64'(1));
    check("t6_restart_reqid", 64'(o_reqid), 64'(0));
    drain();

    // Randomized traffic with varying commit pressure.
    fill_en = 1'b1;
    ack_mode = 2;
    commit_mode = 2;
    repeat (1500) step();
    commit_mode = 4;
    repeat (1500) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Time-limit guard: the bench should never reach this.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
